shift_deser: RTL

//   Serial-in/parallel-out receiver: the far end of the team's 3-bit shift register link.
//   - Collects WIDTH serial bits into a parallel word, MSB-first or LSB-first.
//   - Presents the word on out with a one-cycle out_valid strobe.
//   - Sits between a serial bit source and parallel consumer logic; framing is set by a start pulse.

---
 rtl/shift_deser.sv | 97 +++++++++
 1 files changed

// File: rtl/shift_deser.sv
// Serial-in/parallel-out receiver: assembles WIDTH serial bits into a word, MSB- or LSB-first,
// framed by a start pulse, and presents it with a one-cycle valid strobe.
module shift_deser #(
    parameter int unsigned WIDTH = 3,
    parameter int unsigned CNT_W = 2
) (
    input  logic             i_clk,
    input  logic             i_clr,
    input  logic             i_start,
    input  logic             i_msb_first,
    input  logic             i_sin,
    input  logic             i_sin_valid,
    output logic [WIDTH-1:0] o_out,
    output logic             o_out_valid,
    output logic             o_busy,
    output logic             o_overrun
);

    typedef enum logic {StIdle, StRecv} state_t;

    state_t             r_state, w_state_d;
    logic [WIDTH-1:0]   r_sreg, w_sreg_d;
    logic [CNT_W-1:0]   r_cnt, w_cnt_d;
    logic               r_dir, w_dir_d;
    logic [WIDTH-1:0]   r_out, w_out_d;
    logic               r_out_valid, w_out_valid_d;
    logic               r_overrun, w_overrun_d;
    logic [WIDTH-1:0]   w_shifted;

    // Direction is latched at start so mid-word msb_first changes cannot reorder a word.
    assign w_shifted = r_dir ? {r_sreg[WIDTH-2:0], i_sin} : {i_sin, r_sreg[WIDTH-1:1]};

    always_ff @(posedge i_clk or posedge i_clr) begin
        if (i_clr) begin
            r_state     <= StIdle;
            r_sreg      <= '0;
            r_cnt       <= '0;
            r_dir       <= 1'b0;
            r_out       <= '0;
            r_out_valid <= 1'b0;
            r_overrun   <= 1'b0;
        end else begin
            r_state     <= w_state_d;
            r_sreg      <= w_sreg_d;
            r_cnt       <= w_cnt_d;
            r_dir       <= w_dir_d;
            r_out       <= w_out_d;
            r_out_valid <= w_out_valid_d;
            r_overrun   <= w_overrun_d;
        end
    end

    always_comb begin
        w_state_d     = r_state;
        w_sreg_d      = r_sreg;
        w_cnt_d       = r_cnt;
        w_dir_d       = r_dir;
        w_out_d       = r_out;
        w_out_valid_d = 1'b0;
        w_overrun_d   = r_overrun;
        unique case (r_state)
            StIdle: begin
                // A sin_valid coincident with start is framing, not data, and is not an overrun.
                if (i_start) begin
                    w_state_d   = StRecv;
                    w_dir_d     = i_msb_first;
                    w_sreg_d    = '0;
                    w_cnt_d     = '0;
                    w_overrun_d = 1'b0;
                end else if (i_sin_valid) begin
                    w_overrun_d = 1'b1;
                end
            end
            StRecv: begin
                if (i_sin_valid) begin
                    if (r_cnt == CNT_W'(WIDTH - 1)) begin
                        w_out_d       = w_shifted;
                        w_out_valid_d = 1'b1;
                        w_state_d     = StIdle;
                        w_cnt_d       = '0;
                        w_sreg_d      = '0;
                    end else begin
                        w_sreg_d = w_shifted;
                        w_cnt_d  = r_cnt + CNT_W'(1);
                    end
                end
            end
            default: w_state_d = StIdle;
        endcase
    end

    assign o_out       = r_out;
    assign o_out_valid = r_out_valid;
    assign o_busy      = (r_state == StRecv);
    assign o_overrun   = r_overrun;

endmodule
